// File: rtl/memctl.sv
`default_nettype none
// ============================================================================
//  Module      : memctl
//  Description : Memory-side responder that turns CPU byte/word requests into
//                timed strobe cycles on an external 8-bit asynchronous SRAM.
//                Words are little-endian and take two byte phases (LO, HI).
//  Revision    : 1.0  initial release
// ============================================================================
module memctl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic        MEM_WORD,
  input  logic [15:0] ADDR,
  input  logic [15:0] WDATA,
  output logic [15:0] RDATA,
  output logic        DONE,
  output logic        BUSY,
  output logic        ALIGN_ERR,
  output logic [15:0] SR_A,
  output logic [7:0]  SR_DQ_O,
  input  logic [7:0]  SR_DQ_I,
  output logic        SR_DQ_OE,
  output logic        SR_CE_N,
  output logic        SR_OE_N,
  output logic        SR_WE_N
);

  // Last value of the wait counter inside one strobe (strobe = WAIT_CYCLES+1 cycles)
  localparam logic [3:0] c_wait_last = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_phase;        // 0 = LO byte (even address), 1 = HI byte
  logic        w_phase_nxt;
  logic [3:0]  r_wait_cnt;
  logic        r_is_write;
  logic        r_is_word;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_done;
  logic        r_align_err;
  logic        w_done_nxt;
  logic        w_phase_end;
  logic        w_accept;
  logic        w_strobe_last;

  // BUSY is exactly "not idle", so acceptance only happens while BUSY=0
  assign w_accept      = (r_state == ST_IDLE) && (MEM_READ || MEM_WRITE);
  assign w_strobe_last = (r_state == ST_STROBE) && (r_wait_cnt == c_wait_last);

  // Next-state logic: sequencing through strobe, recovery and byte phases
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_done_nxt  = 1'b0;
    w_phase_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_STROBE;
          w_phase_nxt = 1'b0;
        end
      end
      ST_STROBE: begin
        if (w_strobe_last) begin
          if (r_is_write) begin
            w_state_nxt = ST_RECOVER;
          end else begin
            w_phase_end = 1'b1;
          end
        end
      end
      ST_RECOVER: begin
        w_phase_end = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_phase_end) begin
      if (r_is_word && !r_phase) begin
        w_state_nxt = ST_STROBE;
        w_phase_nxt = 1'b1;
      end else begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = 1'b0;
        w_done_nxt  = 1'b1;
      end
    end
  end

  // State, request latches, wait counter, pulses and read-data capture
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_phase     <= 1'b0;
      r_wait_cnt  <= 4'd0;
      r_is_write  <= 1'b0;
      r_is_word   <= 1'b0;
      r_addr      <= 16'h0000;
      r_wdata     <= 16'h0000;
      r_rdata     <= 16'h0000;
      r_done      <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_done      <= w_done_nxt;
      r_align_err <= w_accept && MEM_WORD && ADDR[0];

      if ((r_state == ST_STROBE) && !w_strobe_last) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end else begin
        r_wait_cnt <= 4'd0;
      end

      if (w_accept) begin
        // Word accesses are forced even, so the HI byte never wraps past 0xFFFF
        r_addr     <= MEM_WORD ? {ADDR[15:1], 1'b0} : ADDR;
        r_wdata    <= WDATA;
        r_is_write <= MEM_WRITE;
        r_is_word  <= MEM_WORD;
      end

      if (w_strobe_last && !r_is_write) begin
        if (!r_is_word) begin
          r_rdata <= {8'h00, SR_DQ_I};
        end else if (!r_phase) begin
          r_rdata[7:0] <= SR_DQ_I;
        end else begin
          r_rdata[15:8] <= SR_DQ_I;
        end
      end
    end
  end

  assign BUSY      = (r_state != ST_IDLE);
  assign DONE      = r_done;
  assign ALIGN_ERR = r_align_err;
  assign RDATA     = r_rdata;

  // HI phase sets bit 0 of the (already even) word address
  assign SR_A    = {r_addr[15:1], r_addr[0] | r_phase};
  assign SR_DQ_O = r_phase ? r_wdata[15:8] : r_wdata[7:0];

  // Strobes: OE only in read strobes, WE only in write strobes, so they never overlap;
  // the data driver is enabled only for writes, keeping it off whenever OE is low.
  assign SR_CE_N  = (r_state == ST_IDLE);
  assign SR_OE_N  = !((r_state == ST_STROBE) && !r_is_write);
  assign SR_WE_N  = !((r_state == ST_STROBE) && r_is_write);
  assign SR_DQ_OE = (r_state != ST_IDLE) && r_is_write;

endmodule
`default_nettype wire

// File: tb/tb_memctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memctl
//  Description : Directed bench for memctl; one instance with WAIT_CYCLES=2,
//                one with WAIT_CYCLES=0, each on its own behavioural SRAM.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A (WAIT_CYCLES=2)
  logic        a_rst, a_rd, a_wr, a_word;
  logic [15:0] a_addr, a_wdata, a_rdata, a_sra;
  logic        a_done, a_busy, a_aerr, a_dqoe, a_ce, a_oe, a_we;
  logic [7:0]  a_dqo, a_dqi;
  logic [7:0]  mem_a [0:65535];

  // Instance B (WAIT_CYCLES=0)
  logic        b_rst, b_rd, b_wr, b_word;
  logic [15:0] b_addr, b_wdata, b_rdata, b_sra;
  logic        b_done, b_busy, b_aerr, b_dqoe, b_ce, b_oe, b_we;
  logic [7:0]  b_dqo, b_dqi;
  logic [7:0]  mem_b [0:65535];

  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;
  int dcnt;

  memctl #(.WAIT_CYCLES(2)) dut_a (
    .CLOCK(clk), .RESET(a_rst), .MEM_READ(a_rd), .MEM_WRITE(a_wr), .MEM_WORD(a_word),
    .ADDR(a_addr), .WDATA(a_wdata), .RDATA(a_rdata), .DONE(a_done), .BUSY(a_busy),
    .ALIGN_ERR(a_aerr), .SR_A(a_sra), .SR_DQ_O(a_dqo), .SR_DQ_I(a_dqi),
    .SR_DQ_OE(a_dqoe), .SR_CE_N(a_ce), .SR_OE_N(a_oe), .SR_WE_N(a_we)
  );

  memctl #(.WAIT_CYCLES(0)) dut_b (
    .CLOCK(clk), .RESET(b_rst), .MEM_READ(b_rd), .MEM_WRITE(b_wr), .MEM_WORD(b_word),
    .ADDR(b_addr), .WDATA(b_wdata), .RDATA(b_rdata), .DONE(b_done), .BUSY(b_busy),
    .ALIGN_ERR(b_aerr), .SR_A(b_sra), .SR_DQ_O(b_dqo), .SR_DQ_I(b_dqi),
    .SR_DQ_OE(b_dqoe), .SR_CE_N(b_ce), .SR_OE_N(b_oe), .SR_WE_N(b_we)
  );

  // Asynchronous SRAM models: combinational read, write latched mid-cycle
  assign a_dqi = (!a_ce && !a_oe) ? mem_a[a_sra] : 8'h00;
  assign b_dqi = (!b_ce && !b_oe) ? mem_b[b_sra] : 8'h00;

  always @(negedge clk) begin
    if (!a_ce && !a_we) mem_a[a_sra] = a_dqo;
    if (!b_ce && !b_we) mem_b[b_sra] = b_dqo;
  end

  // Bus-contention monitor
  always @(negedge clk) begin
    if ((!a_oe && !a_we) || (a_dqoe && !a_oe)) viol = viol + 1;
    if ((!b_oe && !b_we) || (b_dqoe && !b_oe)) viol = viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Called at a negedge; request is seen at the next posedge (E0) and
  // the task returns at the negedge inside cycle 1.
  task automatic a_issue(input logic rd, input logic wr, input logic word,
                         input logic [15:0] addr, input logic [15:0] wdata);
    a_rd = rd; a_wr = wr; a_word = word; a_addr = addr; a_wdata = wdata;
    @(negedge clk);
    a_rd = 1'b0; a_wr = 1'b0;
  endtask

  task automatic b_issue(input logic rd, input logic wr, input logic word,
                         input logic [15:0] addr, input logic [15:0] wdata);
    b_rd = rd; b_wr = wr; b_word = word; b_addr = addr; b_wdata = wdata;
    @(negedge clk);
    b_rd = 1'b0; b_wr = 1'b0;
  endtask

  initial begin
    a_rst = 1'b1; a_rd = 1'b0; a_wr = 1'b0; a_word = 1'b0; a_addr = '0; a_wdata = '0;
    b_rst = 1'b1; b_rd = 1'b0; b_wr = 1'b0; b_word = 1'b0; b_addr = '0; b_wdata = '0;
    mem_a[16'h1234] = 8'h55; mem_a[16'h1235] = 8'hA7;
    mem_a[16'h3000] = 8'h11; mem_a[16'h3001] = 8'h22;
    mem_b[16'hFFFE] = 8'h01; mem_b[16'hFFFF] = 8'h02;
    repeat (3) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    repeat (5) @(negedge clk);

    // Reset / idle state
    chk("rst_ce", a_ce, 1); chk("rst_oe", a_oe, 1); chk("rst_we", a_we, 1);
    chk("rst_dqoe", a_dqoe, 0); chk("rst_busy", a_busy, 0); chk("rst_done", a_done, 0);
    chk("rst_rdata", a_rdata, 16'h0000); chk("rst_sra", a_sra, 16'h0000);
    chk("rst_aerr", a_aerr, 0); chk("rst_b_busy", b_busy, 0);

    // W=2 byte read of 0x1235: strobe cycles 1-3, DONE in cycle 4
    a_issue(1'b1, 1'b0, 1'b0, 16'h1235, 16'h0000);
    for (int c = 1; c <= 3; c++) begin
      chk("brd_busy", a_busy, 1); chk("brd_oe", a_oe, 0); chk("brd_we", a_we, 1);
      chk("brd_sra", a_sra, 16'h1235); chk("brd_dqoe", a_dqoe, 0); chk("brd_nodone", a_done, 0);
      @(negedge clk);
    end
    chk("brd_done", a_done, 1); chk("brd_busy4", a_busy, 0); chk("brd_oe4", a_oe, 1);
    chk("brd_ce4", a_ce, 1); chk("brd_rdata", a_rdata, 16'h00A7);
    @(negedge clk);
    chk("brd_done_pulse", a_done, 0);

    // W=2 word write 0xBEEF at 0x2000: strobe/recover per byte, DONE in cycle 9
    a_issue(1'b0, 1'b1, 1'b1, 16'h2000, 16'hBEEF);
    for (int c = 1; c <= 8; c++) begin
      chk("wwr_we", a_we, (c == 4 || c == 8) ? 1 : 0);
      chk("wwr_oe", a_oe, 1); chk("wwr_ce", a_ce, 0); chk("wwr_dqoe", a_dqoe, 1);
      chk("wwr_sra", a_sra, (c > 4) ? 16'h2001 : 16'h2000);
      chk("wwr_dqo", a_dqo, (c > 4) ? 8'hBE : 8'hEF);
      chk("wwr_nodone", a_done, 0);
      @(negedge clk);
    end
    chk("wwr_done", a_done, 1); chk("wwr_busy9", a_busy, 0); chk("wwr_dqoe9", a_dqoe, 0);
    chk("wwr_we9", a_we, 1); chk("wwr_rdata_kept", a_rdata, 16'h00A7);
    chk("wwr_mem_lo", mem_a[16'h2000], 8'hEF); chk("wwr_mem_hi", mem_a[16'h2001], 8'hBE);
    @(negedge clk);

    // W=2 word read back: DONE in cycle 7
    a_issue(1'b1, 1'b0, 1'b1, 16'h2000, 16'h0000);
    for (int c = 1; c <= 6; c++) begin
      chk("wrd_nodone", a_done, 0);
      @(negedge clk);
    end
    chk("wrd_done", a_done, 1); chk("wrd_rdata", a_rdata, 16'hBEEF);
    @(negedge clk);

    // Misaligned word read of 0x3001
    a_issue(1'b1, 1'b0, 1'b1, 16'h3001, 16'h0000);
    chk("al_pulse", a_aerr, 1); chk("al_sra_lo", a_sra, 16'h3000);
    @(negedge clk);
    chk("al_pulse_end", a_aerr, 0);
    repeat (2) @(negedge clk);
    chk("al_sra_hi", a_sra, 16'h3001);
    repeat (3) @(negedge clk);
    chk("al_done", a_done, 1); chk("al_rdata", a_rdata, 16'h2211);
    @(negedge clk);

    // Reset during cycle 2 of a word write
    a_issue(1'b0, 1'b1, 1'b1, 16'h4000, 16'h1234);
    @(negedge clk);
    chk("rw_we_c2", a_we, 0);
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    chk("rw_ce", a_ce, 1); chk("rw_oe", a_oe, 1); chk("rw_we", a_we, 1);
    chk("rw_dqoe", a_dqoe, 0); chk("rw_busy", a_busy, 0); chk("rw_done", a_done, 0);
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      dcnt += int'(a_done);
    end
    chk("rw_no_done", dcnt, 0);

    // W=0 byte write, then read requested in its DONE cycle
    b_issue(1'b0, 1'b1, 1'b0, 16'h0010, 16'h335A);
    chk("b2b_we", b_we, 0); chk("b2b_dqo", b_dqo, 8'h5A); chk("b2b_sra", b_sra, 16'h0010);
    @(negedge clk);
    chk("b2b_rec_we", b_we, 1); chk("b2b_rec_ce", b_ce, 0); chk("b2b_rec_dqoe", b_dqoe, 1);
    @(negedge clk);
    chk("b2b_wdone", b_done, 1); chk("b2b_wbusy", b_busy, 0);
    chk("b2b_rdata_kept", b_rdata, 16'h0000); chk("b2b_mem", mem_b[16'h0010], 8'h5A);
    b_issue(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    chk("b2b_rbusy", b_busy, 1); chk("b2b_roe", b_oe, 0); chk("b2b_rsra", b_sra, 16'h0010);
    @(negedge clk);
    chk("b2b_rdone", b_done, 1); chk("b2b_rdata", b_rdata, 16'h005A);
    @(negedge clk);

    // W=0 request with both MEM_READ and MEM_WRITE high -> write
    b_issue(1'b1, 1'b1, 1'b0, 16'h0020, 16'h00C3);
    chk("both_we", b_we, 0); chk("both_oe", b_oe, 1);
    repeat (2) @(negedge clk);
    chk("both_done", b_done, 1); chk("both_mem", mem_b[16'h0020], 8'hC3);
    chk("both_rdata_kept", b_rdata, 16'h005A);
    @(negedge clk);

    // W=0 word read of 0xFFFF -> forced to 0xFFFE, no wrap
    b_issue(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
    chk("wrap_aerr", b_aerr, 1); chk("wrap_sra_lo", b_sra, 16'hFFFE);
    @(negedge clk);
    chk("wrap_sra_hi", b_sra, 16'hFFFF);
    @(negedge clk);
    chk("wrap_done", b_done, 1); chk("wrap_rdata", b_rdata, 16'h0201);
    @(negedge clk);

    chk("contention", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memctl.md
Name: memctl

Overview:
- Memory-side responder for the CPU's MEM_READ/MEM_WRITE/MEM_WORD request interface.
- Converts each byte or word request into timed cycles on an external 8-bit asynchronous SRAM.
- Returns read data to the CPU datapath and signals completion.
- Sits between the sequencer/datapath and the board SRAM pins.

Parameters:
WAIT_CYCLES, 2, extra SRAM strobe cycles per byte phase (legal 0..15); each strobe lasts WAIT_CYCLES+1 cycles.

Ports:
CLOCK  input  1  system clock, all logic on rising edge
RESET  input  1  synchronous, active-high reset
MEM_READ  input  1  read request, sampled only when BUSY=0
MEM_WRITE  input  1  write request, sampled only when BUSY=0
MEM_WORD  input  1  1 = 16-bit access, 0 = byte access
ADDR  input  16  byte address
WDATA  input  16  write data; byte writes use WDATA[7:0]
RDATA  output  16  read data, registered
DONE  output  1  one-cycle completion pulse, for reads and writes
BUSY  output  1  access in progress
ALIGN_ERR  output  1  one-cycle pulse: word request with ADDR[0]=1
SR_A  output  16  SRAM address
SR_DQ_O  output  8  SRAM write data
SR_DQ_I  input  8  SRAM read data
SR_DQ_OE  output  1  drive enable for SR_DQ_O
SR_CE_N  output  1  chip enable, active low
SR_OE_N  output  1  output enable, active low
SR_WE_N  output  1  write enable, active low

Behaviour:
- Clock and reset: CLOCK and RESET; reset is synchronous, active-high.
- Reset values:
  - SR_CE_N, SR_OE_N and SR_WE_N = 1.
  - SR_DQ_OE, BUSY, DONE and ALIGN_ERR = 0.
  - RDATA, SR_A and SR_DQ_O = 0.
  - State = IDLE; wait counter = 0.
- Reset mid-access: the access is abandoned immediately and no DONE is issued. SRAM may hold partial write data.
- State set: IDLE, STROBE, RECOVER.
- Byte phase tracking: a phase bit selects LO (first byte) or HI (second byte of a word).
- Request acceptance (IDLE, edge E0):
  - Acceptance happens at any edge where BUSY=0 and (MEM_READ | MEM_WRITE).
  - If both are high, the access is a write.
  - ADDR, WDATA, MEM_WORD and direction are latched at acceptance.
  - BUSY goes to 1 for the next cycle.
- Word alignment:
  - A word access forces ADDR[0] to 0.
  - If the supplied ADDR[0] was 1, ALIGN_ERR pulses in cycle 1 and the access proceeds normally.
- Endianness: little-endian. LO phase uses even address A with WDATA[7:0] or RDATA[7:0]; HI phase uses A+1 with bits [15:8].
- Byte read data: the byte goes to RDATA[7:0] and RDATA[15:8] = 0 (zero-extend).
- STROBE state:
  - Lasts WAIT_CYCLES+1 cycles, counted by the wait counter.
  - SR_CE_N=0 and SR_A is valid.
  - Read: SR_OE_N=0 and SR_DQ_OE=0; SR_DQ_I is captured into RDATA at the edge that ends the last strobe cycle.
  - Write: SR_WE_N=0, SR_DQ_OE=1 and SR_DQ_O is valid.
- RECOVER state (writes only):
  - Lasts 1 cycle with SR_WE_N=1.
  - SR_CE_N=0; SR_A, SR_DQ_O and SR_DQ_OE=1 are held (data hold time).
  - Reads have no RECOVER.
- Transitions:
  - IDLE→STROBE(LO) on acceptance.
  - STROBE→RECOVER (write) or phase end (read).
  - Phase end: if word and LO, go to STROBE(HI); otherwise go to IDLE with DONE.
- RDATA stability: no update between accesses. RDATA is unchanged by writes.
- Completion cycle:
  - DONE=1 and BUSY=0 for exactly one cycle after the final phase.
  - All SRAM strobes are inactive and SR_DQ_OE=0.
  - A new request may be accepted at the edge ending the DONE cycle (back-to-back).
- Latency, counted in cycles from E0 to the DONE cycle, with W = WAIT_CYCLES:
  - byte read W+2
  - word read 2W+3
  - byte write W+3
  - word write 2W+5
- Request handling while busy: requests present while BUSY=1 are ignored. The requester pulses the request for one cycle and waits for DONE.
- Address wrap: a word access at 0xFFFE uses addresses 0xFFFE and 0xFFFF. A forced-even 0xFFFF becomes 0xFFFE, so there is no wrap past 0xFFFF.
- Bus contention: SR_OE_N and SR_WE_N are never both 0. SR_DQ_OE is never 1 while SR_OE_N=0.

Test Plan:
- Reset, then idle 5 cycles -> CE_N/OE_N/WE_N=1, DQ_OE=0, BUSY=0, DONE=0, RDATA=0.
- W=2, byte read ADDR=0x1235, SRAM[0x1235]=0xA7 -> SR_A=0x1235 and OE_N=0 in cycles 1-3; DONE in cycle 4; RDATA=0x00A7.
- W=2, word write ADDR=0x2000, WDATA=0xBEEF:
  - WE_N=0 in cycles 1-3 with SR_A=0x2000 and DQ=0xEF.
  - Recovery in cycle 4.
  - WE_N=0 in cycles 5-7 with SR_A=0x2001 and DQ=0xBE.
  - Recovery in cycle 8; DONE in cycle 9.
  - A later word read of 0x2000 returns RDATA=0xBEEF at cycle 7.
- Word read ADDR=0x3001 -> ALIGN_ERR pulses in cycle 1; access uses 0x3000/0x3001; RDATA = {SRAM[0x3001], SRAM[0x3000]}.
- W=0:
  - Back-to-back: a byte write, then a read re-requested in its DONE cycle -> read accepted there, no idle gap, read returns the written byte.
  - Request with MEM_READ and MEM_WRITE both high -> performed as a write.
- RESET asserted in cycle 2 of a word write -> next cycle all strobes are inactive, BUSY=0, and no DONE pulse follows.
